// File: rtl/idelay_tap_ctrl_if.sv
// Command/response handshake and per-lane strobe bus between PHY calibration and the delay lanes.
// master = calibration logic plus delay primitives; slave = idelay_tap_ctrl.
interface idelay_tap_ctrl_if #(
    parameter int LANES = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_lane;
    logic [1:0]         cmd_op;
    logic [4:0]         cmd_value;
    logic               rsp_valid;
    logic [4:0]         rsp_tap;
    logic               rsp_err;
    logic [LANES-1:0]   dly_ld;
    logic [LANES-1:0]   dly_ce;
    logic               dly_inc;
    logic [4:0]         dly_cntvaluein;
    logic [5*LANES-1:0] dly_cntvalueout;

    modport master (
        output cmd_valid, cmd_lane, cmd_op, cmd_value, dly_cntvalueout,
        input  cmd_ready, rsp_valid, rsp_tap, rsp_err,
        input  dly_ld, dly_ce, dly_inc, dly_cntvaluein
    );

    modport slave (
        input  cmd_valid, cmd_lane, cmd_op, cmd_value, dly_cntvalueout,
        output cmd_ready, rsp_valid, rsp_tap, rsp_err,
        output dly_ld, dly_ce, dly_inc, dly_cntvaluein
    );
endinterface

// File: rtl/idelay_tap_ctrl.sv
// Tap sequencer for VAR_LOAD input-delay lanes: turns load/step/reset commands into LD/CE/INC
// strobes, clamps relative moves at taps 0 and 31, settles, then reports the read-back tap.
module idelay_tap_ctrl #(
    parameter int LANES         = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input logic              sys_clk,
    input logic              sys_rst,
    idelay_tap_ctrl_if.slave bus
);
    localparam int              SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0]      LANES_W     = 4'(LANES);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_SETTLE,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    lane_q, lane_d;
    logic [4:0]    loadVal_q, loadVal_d;
    logic [4:0]    exp_q, exp_d;
    logic          clamp_q, clamp_d;
    logic          dir_q, dir_d;
    logic [4:0]    steps_q, steps_d;
    logic          phase_q, phase_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [4:0]    rspTap_q, rspTap_d;
    logic          rspErr_q, rspErr_d;

    logic [4:0]    cur;
    logic [4:0]    rb;
    logic          badLane;
    logic [5:0]    sum;
    logic [6:0]    diff;
    logic [4:0]    relExp;
    logic [4:0]    k;

    function automatic logic [4:0] tapOf(input logic [5*LANES-1:0] vec, input logic [2:0] lane);
        logic [4:0] t;
        t = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == 3'(i)) t = vec[5*i +: 5];
        end
        return t;
    endfunction

    // Relative targets are worked out in wider arithmetic so a move saturates instead of wrapping.
    always_comb begin
        cur     = tapOf(bus.dly_cntvalueout, bus.cmd_lane);
        rb      = tapOf(bus.dly_cntvalueout, lane_q);
        badLane = ({1'b0, bus.cmd_lane} >= LANES_W);
        sum     = {1'b0, cur} + {1'b0, bus.cmd_value};
        diff    = {2'b00, cur} - {2'b00, bus.cmd_value};
        if (bus.cmd_op == 2'b01) begin
            relExp = sum[5] ? 5'd31 : sum[4:0];
        end else begin
            relExp = diff[6] ? 5'd0 : diff[4:0];
        end
        k = (relExp >= cur) ? (relExp - cur) : (cur - relExp);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            lane_q    <= '0;
            loadVal_q <= '0;
            exp_q     <= '0;
            clamp_q   <= 1'b0;
            dir_q     <= 1'b0;
            steps_q   <= '0;
            phase_q   <= 1'b0;
            settle_q  <= '0;
            rspTap_q  <= '0;
            rspErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            loadVal_q <= loadVal_d;
            exp_q     <= exp_d;
            clamp_q   <= clamp_d;
            dir_q     <= dir_d;
            steps_q   <= steps_d;
            phase_q   <= phase_d;
            settle_q  <= settle_d;
            rspTap_q  <= rspTap_d;
            rspErr_q  <= rspErr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        loadVal_d = loadVal_q;
        exp_d     = exp_q;
        clamp_d   = clamp_q;
        dir_d     = dir_q;
        steps_d   = steps_q;
        phase_d   = phase_q;
        settle_d  = '0;
        rspTap_d  = rspTap_q;
        rspErr_d  = rspErr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    lane_d  = bus.cmd_lane;
                    dir_d   = (bus.cmd_op == 2'b01);
                    phase_d = 1'b0;
                    if (badLane) begin
                        rspTap_d = '0;
                        rspErr_d = 1'b1;
                        state_d  = S_RESP;
                    end else if (bus.cmd_op == 2'b00 || bus.cmd_op == 2'b11) begin
                        loadVal_d = (bus.cmd_op == 2'b00) ? bus.cmd_value : 5'd0;
                        exp_d     = (bus.cmd_op == 2'b00) ? bus.cmd_value : 5'd0;
                        clamp_d   = 1'b0;
                        state_d   = S_LOAD;
                    end else begin
                        exp_d   = relExp;
                        clamp_d = (k != bus.cmd_value);
                        steps_d = k;
                        state_d = (k == 5'd0) ? S_SETTLE : S_STEP;
                    end
                end
            end
            S_LOAD: state_d = S_SETTLE;
            // Each step is one CE-high cycle followed by one CE-low cycle.
            S_STEP: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    steps_d = steps_q - 5'd1;
                    if (steps_q == 5'd1) state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + SW'(1);
                if (settle_q == SETTLE_LAST) begin
                    rspTap_d = rb;
                    rspErr_d = clamp_q | (rb != exp_q);
                    settle_d = '0;
                    state_d  = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode from the state register so an asynchronous reset drops them at once.
    always_comb begin
        bus.dly_ld = '0;
        bus.dly_ce = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.dly_ld[i] = (state_q == S_LOAD) && (lane_q == 3'(i));
            bus.dly_ce[i] = (state_q == S_STEP) && !phase_q && (lane_q == 3'(i));
        end
    end

    assign bus.dly_inc        = (state_q == S_STEP) && dir_q;
    assign bus.dly_cntvaluein = (state_q == S_LOAD) ? loadVal_q : 5'd0;
    assign bus.cmd_ready      = (state_q == S_IDLE) && !sys_rst;
    assign bus.rsp_valid      = (state_q == S_RESP);
    assign bus.rsp_tap        = rspTap_q;
    assign bus.rsp_err        = rspErr_q;
endmodule

// File: doc/idelay_tap_ctrl.md
# idelay_tap_ctrl

Sequencing controller for a bank of input-delay lanes (VAR_LOAD mode, PIPE_SEL off) in the liteeth ASIC port. It accepts one tap command at a time: absolute load, relative increment or decrement, or lane reset. It converts each command into LD/CE/INC strobes for the addressed lane, clamps relative moves at the 0/31 tap limits, waits for the count to settle, then reads back CNTVALUEOUT and reports the result. It sits between the PHY calibration logic and the per-lane delay primitives, which share its clock.

## Interface
- LANES, 4: number of delay lanes, 1..8
- SETTLE_CYCLES, 4: wait cycles after the last strobe before readback, ≥1
- sys_clk  in  1  controller clock; also drives the delay lanes' C
- sys_rst  in  1  reset, asynchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle, command accepted on valid&ready
- cmd_lane  in  3  target lane index
- cmd_op  in  2  00 load, 01 increment, 10 decrement, 11 reset lane to tap 0
- cmd_value  in  5  tap value for load; step count for increment/decrement
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_tap  out  5  tap read back from the lane
- rsp_err  out  1  clamped, mismatched or bad lane
- dly_ld  out  LANES  per-lane load strobe
- dly_ce  out  LANES  per-lane step enable
- dly_inc  out  1  shared direction, 1 = increment
- dly_cntvaluein  out  5  shared load value
- dly_cntvalueout  in  5*LANES  per-lane tap readback, lane i at bits [5i+4:5i]

## Operation
- States:
  - IDLE → LOAD: op 00 or 11
  - IDLE → STEP: op 01 or 10 with a non-zero computed step count
  - IDLE → SETTLE: op 01 or 10 with a zero computed step count
  - IDLE → RESP: cmd_lane ≥ LANES
  - LOAD → SETTLE
  - STEP → SETTLE
  - SETTLE → RESP
  - RESP → IDLE
- cmd_ready = 1 only in IDLE. On acceptance, latch lane, op and value; for ops 01/10 also latch cur = dly_cntvalueout[lane].
- LOAD: dly_ld[lane] = 1 for one cycle. dly_cntvaluein = value for op 00, 0 for op 11. exp = that value.
- Increment: exp = min(cur+value, 31), computed in 6-bit arithmetic.
- Decrement: exp = max(cur−value, 0), signed compare.
- k = |exp−cur|. clamp = 1 when k ≠ value.
- STEP: k pulses, each dly_ce[lane] = 1 for one cycle followed by one low cycle. dly_inc is held at the direction for the whole STEP state.
  - dly_inc is 0 outside STEP.
  - A relative move never wraps the primitive's 31↔0 counter.
- SETTLE: count SETTLE_CYCLES cycles. On the last cycle, sample rb = dly_cntvalueout[lane].
- RESP: rsp_valid = 1, rsp_tap = rb, rsp_err = clamp | (rb ≠ exp).
  - Bad lane: no strobes, rsp_tap = 0, rsp_err = 1.
- rsp_tap and rsp_err hold their values until the next RESP.
- Only the addressed lane's bits of dly_ld and dly_ce ever assert; all others stay 0.
- cmd_* is ignored outside IDLE.

## Timing
- Reset values: cmd_ready 0 while sys_rst is high, 1 in the first cycle after deassert. rsp_valid, rsp_tap, rsp_err, dly_ld, dly_ce, dly_inc and dly_cntvaluein are all 0. State is IDLE.
- Reset mid-command aborts immediately. Strobes drop asynchronously, no response is issued and the latched command is discarded.
- Cycle 1 is the cycle after the accepting edge. D = 1 (load/reset), 2k (step), 0 (k = 0), 0 (bad lane).
- SETTLE occupies cycles D+1..D+SETTLE_CYCLES. rsp_valid is high in cycle D+SETTLE_CYCLES+1.
  - Bad lane skips SETTLE: rsp_valid is high in cycle 1.
- cmd_ready is high again the cycle after rsp_valid. Back-to-back commands have one idle cycle minimum between them.
- Load case: dly_ld is high in cycle 1. The primitive updates at the end of cycle 1, so readback is stable from cycle 2.
- Step case: dly_ce is high in cycles 1, 3, …, 2k−1.

## Test plan
- Load: reset, then lane 2, op 00, value 17, SETTLE_CYCLES 4 → dly_ld[2] high in cycle 1 with dly_cntvaluein = 17; rsp_valid in cycle 6 with tap 17, err 0; cmd_ready high in cycle 7.
- Increment with clamp: lane 0 at 28, op 01, value 6 → 3 CE pulses in cycles 1/3/5 with dly_inc = 1; rsp in cycle 11 with tap 31, err 1; lane is never at 0.
- Decrement exact and zero-step: lane 1 at 5, op 10, value 5 → 5 pulses, tap 0, err 0. Then op 10, value 3 → no pulses, rsp in cycle 5 with tap 0, err 1.
- Bad lane and reset-lane op:
  - LANES = 3, cmd_lane 3 → no strobes, rsp in cycle 1 with tap 0, err 1.
  - op 11 on lane 2 at tap 9 → dly_ld[2] with value 0, tap 0, err 0.
- Mismatch and reset abort:
  - Force lane readback stuck at 4 and load 10 → tap 4, err 1.
  - Assert sys_rst during STEP after the 2nd pulse → all strobes 0 immediately, no rsp_valid, cmd_ready 1 the cycle after deassert, next command executes normally.
